m_dmem_resp: RTL
================

M_DMEM_RESP -- requirements
Module: m_dmem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning memory size in 32-bit words (power of two).
REQ-002 The block SHALL have parameter LAT, default 2, meaning accept-to-response latency in cycles (legal range 1..15).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: w_clk and w_rst.
REQ-004 w_clk  input  1  clock; all state changes on its rising edge.
REQ-005 w_rst  input  1  synchronous active-high reset.
REQ-006 w_req_valid  input  1  initiator presents a request.
REQ-007 w_req_ready  output  1  block accepts a request this cycle.
REQ-008 w_req_we  input  1  1 = store, 0 = load.
REQ-009 w_req_addr  input  32  byte address.
REQ-010 w_req_wdata  input  32  store data, little-endian.
REQ-011 w_req_be  input  4  store byte enables; bit i covers wdata[8i+7:8i].
REQ-012 w_rsp_valid  output  1  response available.
REQ-013 w_rsp_ready  input  1  initiator takes the response.
REQ-014 w_rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 w_rsp_err  output  1  request was misaligned or out of range.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-017 w_req_ready SHALL be 1 in IDLE only; accept occurs when w_req_valid & w_req_ready at a rising edge.
REQ-018 On accept with LAT=1, the FSM SHALL go IDLE->RESP; with LAT>1, it SHALL go IDLE->WAIT and load a counter with LAT-2.
REQ-019 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter is 0.
REQ-020 w_rsp_valid SHALL be 1 exactly in RESP and SHALL first be visible LAT cycles after the accept edge.
REQ-021 In RESP, w_rsp_rdata and w_rsp_err SHALL be held stable until w_rsp_valid & w_rsp_ready; on that edge the FSM SHALL go RESP->IDLE.
REQ-022 Back-to-back operation SHALL be excluded; minimum request spacing is LAT+1 cycles.
REQ-023 Error SHALL be set when addr[1:0]!=0 or addr[31:2]>=DEPTH; an erroring request SHALL NOT write memory and SHALL return rdata 0, err 1.
REQ-024 A legal store SHALL write the enabled bytes of word addr[31:2] at the accept edge; be=4'b0000 SHALL be a legal no-op returning err 0.
REQ-025 A legal store SHALL return rdata 0, err 0.
REQ-026 A legal load SHALL capture the full word at the accept edge, ignoring be.
REQ-027 A load accepted after a store SHALL observe that store's data.
REQ-028 Inputs SHALL be ignored outside the accept cycle; the initiator may change them freely.
REQ-029 Memory contents SHALL be uninitialised except through stores; no read-modify-write hazard SHALL exist because one request is in flight at a time.

Reset
REQ-030 When w_rst=1 at a rising edge, the block SHALL enter IDLE with w_rsp_valid=0, w_rsp_rdata=0, w_rsp_err=0, and counter=0.
REQ-031 While w_rst=1, w_req_ready SHALL be 0 and no request SHALL be accepted.
REQ-032 Reset mid-operation (WAIT or RESP) SHALL drop the pending response, and a store already accepted SHALL remain written.
REQ-033 Memory array contents SHALL NOT be cleared by reset.

Verification
REQ-034 LAT=2, store addr 0x10, data 0xDEADBEEF, be 0xF, then load 0x10 -> store response at +2 cycles with rdata 0, err 0; load response rdata 0xDEADBEEF, err 0.
REQ-035 Store be=4'b0101 data 0x11223344 over word 0xFFFFFFFF at 0x20, then load -> rdata 0xFF22FF44.
REQ-036 Load addr 0x13 (misaligned) and addr 4*DEPTH (out of range) -> rsp_err 1, rdata 0; a store to 4*DEPTH leaves word 0 unchanged.
REQ-037 Response held with w_rsp_ready=0 for 5 cycles -> rsp_valid, rdata, and err stable, and req_ready stays 0; handshake -> req_ready 1 next cycle.
REQ-038 w_rst asserted one cycle after a load accept (WAIT) -> rsp_valid never rises; store at 0x30 before reset is still readable after reset.
REQ-039 LAT=1, sweep LAT=4 -> rsp_valid exactly 1 and 4 cycles after accept respectively.

Source files
------------

// File: rtl/m_dmem_resp_if.sv
// Request/response bus between an initiator and the m_dmem_resp data memory.
// Ports: request side (valid/ready, we, addr, wdata, be); response side (valid/ready, rdata, err).
// master = initiator, slave = memory block.
interface m_dmem_resp_if;
   logic        w_req_valid;
   logic        w_req_ready;
   logic        w_req_we;
   logic [31:0] w_req_addr;
   logic [31:0] w_req_wdata;
   logic [3:0]  w_req_be;
   logic        w_rsp_valid;
   logic        w_rsp_ready;
   logic [31:0] w_rsp_rdata;
   logic        w_rsp_err;

   modport master (
      output w_req_valid, w_req_we, w_req_addr, w_req_wdata, w_req_be, w_rsp_ready,
      input  w_req_ready, w_rsp_valid, w_rsp_rdata, w_rsp_err
   );

   modport slave (
      input  w_req_valid, w_req_we, w_req_addr, w_req_wdata, w_req_be, w_rsp_ready,
      output w_req_ready, w_rsp_valid, w_rsp_rdata, w_rsp_err
   );
endinterface

// File: rtl/m_dmem_resp.sv
// Single-outstanding word-addressed data memory with byte-enabled stores.
// Latency: response valid LAT cycles after the accept edge (LAT = 1..15).
// Backpressure: one request in flight; req_ready low until the response is taken.
// Ports: w_clk, w_rst (sync active-high), w_bus (slave side of m_dmem_resp_if).
module m_dmem_resp #(
   parameter int DEPTH = 1024,
   parameter int LAT   = 2
) (
   input  logic          w_clk,
   input  logic          w_rst,
   m_dmem_resp_if.slave  w_bus
);

   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // WAIT counts down from LAT-2 so that RESP is entered exactly LAT edges after accept.
   localparam logic [3:0] CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   logic [31:0] mem [DEPTH];

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        vld_q, vld_d;

   logic            accept;
   logic            req_err;
   logic            wr_en;
   logic [IDXW-1:0] idx;

   // Reset dominates: nothing is accepted while w_rst is high.
   assign w_bus.w_req_ready = (state_q == IDLE) && !w_rst;
   assign accept            = w_bus.w_req_valid && w_bus.w_req_ready;
   assign idx               = w_bus.w_req_addr[IDXW+1:2];
   assign req_err           = (w_bus.w_req_addr[1:0] != 2'b00) ||
                              ({2'b00, w_bus.w_req_addr[31:2]} >= 32'(DEPTH));
   assign wr_en             = accept && w_bus.w_req_we && !req_err;

   assign w_bus.w_rsp_valid = vld_q;
   assign w_bus.w_rsp_rdata = rdata_q;
   assign w_bus.w_rsp_err   = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      vld_d   = vld_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               // Load data is captured now, so later input changes cannot disturb it.
               rdata_d = (req_err || w_bus.w_req_we) ? 32'd0 : mem[idx];
               err_d   = req_err;
               if (LAT == 1) begin
                  state_d = RESP;
                  vld_d   = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               vld_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (w_bus.w_rsp_ready) begin
               state_d = IDLE;
               vld_d   = 1'b0;
               rdata_d = 32'd0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            vld_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
      end
   end

   // Storage is never reset; only legal stores modify it.
   always_ff @(posedge w_clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (w_bus.w_req_be[i]) begin
               mem[idx][8*i +: 8] <= w_bus.w_req_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule
